// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// Optional MDU_EARLY_OUT_EN: zero operands / zero divisor skip straight to the sign-fix state.
module mult_div_unit #(
  parameter int N  = 32,
  parameter int CW = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] src_a,
  input  logic [N-1:0] src_b,
  input  logic         hi_we,
  input  logic         lo_we,
  input  logic [N-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  // state | meaning
  // IDLE  | waiting for start; MTHI/MTLO writes accepted
  // CALC  | one shift-add or restoring-divide step per cycle, N cycles
  // FIX   | sign correction; hi/lo written and done raised on exit
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  cnt;
  logic           is_div, neg_q, neg_r, dz;
  logic [N-1:0]   raw_a, mag_b;
  logic [2*N-1:0] acc;
  logic [N-1:0]   rem;

  logic           sgn_op, sa, sb, skip;
  logic [N-1:0]   abs_a, abs_b;
  logic [N:0]     mul_sum, div_sh;
  logic           div_ge;
  logic [N-1:0]   div_nx, quo, rmd;
  logic [2*N-1:0] prod;

  always_comb begin
    sgn_op = ~op[0];
    sa     = sgn_op & src_a[N-1];
    sb     = sgn_op & src_b[N-1];
    abs_a  = sa ? -src_a : src_a;
    abs_b  = sb ? -src_b : src_b;
`ifdef MDU_EARLY_OUT_EN
    skip   = op[1] ? (src_b == '0) : ((src_a == '0) || (src_b == '0));
`else
    skip   = 1'b0;
`endif
  end

  // Multiplier sits in acc low half and shifts out; dividend/quotient share the same bits.
  always_comb begin
    mul_sum = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, mag_b} : '0);
    div_sh  = {rem, acc[N-1]};
    div_ge  = div_sh >= {1'b0, mag_b};
    div_nx  = div_ge ? N'(div_sh - {1'b0, mag_b}) : div_sh[N-1:0];
    prod    = neg_q ? -acc : acc;
    quo     = neg_q ? -acc[N-1:0] : acc[N-1:0];
    rmd     = neg_r ? -rem : rem;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = skip ? FIX : CALC;
      CALC:    if (cnt == '0) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      raw_a  <= '0;
      mag_b  <= '0;
      acc    <= '0;
      rem    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            busy   <= 1'b1;
            cnt    <= CW'(N-1);
            is_div <= op[1];
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            dz     <= op[1] & (src_b == '0);
            raw_a  <= src_a;
            mag_b  <= abs_b;
            rem    <= '0;
            acc    <= skip ? '0 : {{N{1'b0}}, abs_a};
          end
        end
        CALC: begin
          cnt <= cnt - 1'b1;
          if (is_div) begin
            rem          <= div_nx;
            acc[N-1:0]   <= {acc[N-2:0], div_ge};
          end else begin
            acc <= {mul_sum, acc[N-1:1]};
          end
        end
        FIX: begin
          busy <= 1'b0;
          done <= 1'b1;
          // Divide by zero returns the untouched dividend bits, so no sign fix.
          if (dz) begin
            hi <= raw_a;
            lo <= '1;
          end else if (is_div) begin
            hi <= rmd;
            lo <= quo;
          end else begin
            hi <= prod[2*N-1:N];
            lo <= prod[N-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit; expected values hand-computed.
module tb_mult_div_unit;
  localparam int N  = 32;
  localparam int CW = 6;
`ifdef MDU_EARLY_OUT_EN
  localparam int EO_LAT = 1;
`else
  localparam int EO_LAT = N + 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n, start, hi_we, lo_we;
  logic [1:0]   op;
  logic [N-1:0] src_a, src_b, wdata;
  logic         busy, done;
  logic [N-1:0] hi, lo;

  int total = 0;
  int bad   = 0;
  int nb, kd, npulse;

  mult_div_unit #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .hi_we(hi_we), .lo_we(lo_we),
    .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; start is sampled at the following posedge.
  task automatic start_op(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b);
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the negedge where done is seen; kdone = negedges since start_op returned.
  task automatic wait_done(output int nbusy, output int kdone);
    nbusy = 0;
    kdone = -1;
    for (int k = 0; k < 200; k++) begin
      if (done) begin
        kdone = k;
        break;
      end
      if (busy) nbusy++;
      @(negedge clk);
    end
    if (kdone < 0) begin
      total++;
      bad++;
      $error("FAIL timeout observed=no_done expected=done");
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; src_a = '0; src_b = '0; wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_hi",   64'(hi),   64'(0));
    chk("rst_lo",   64'(lo),   64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // MTHI in IDLE
    hi_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi_hi", 64'(hi), 64'h1234);
    chk("mthi_lo", 64'(lo), 64'h0);

    // MULT 7 x -3
    start_op(2'b00, 32'd7, 32'hFFFF_FFFD);
    wait_done(nb, kd);
    chk("mult_busy_cycles", 64'(nb), 64'(N+1));
    chk("mult_done_lat",    64'(kd), 64'(N+1));
    chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(lo), 64'hFFFF_FFEB);
    @(negedge clk);
    chk("mult_done_single", 64'(done), 64'(0));

    // MULTU max x max, then DIVU 100/7 started in the done cycle
    start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(nb, kd);
    chk("multu_hi", 64'(hi), 64'hFFFF_FFFE);
    chk("multu_lo", 64'(lo), 64'h0000_0001);
    start_op(2'b11, 32'd100, 32'd7);
    chk("b2b_busy", 64'(busy), 64'(1));
    wait_done(nb, kd);
    chk("b2b_lat",  64'(kd), 64'(N+1));
    chk("divu_lo", 64'(lo), 64'd14);
    chk("divu_hi", 64'(hi), 64'd2);

    // DIV -7 / 2
    @(negedge clk);
    start_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done(nb, kd);
    chk("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
    chk("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);

    // DIV 7 / -2
    start_op(2'b10, 32'd7, 32'hFFFF_FFFE);
    wait_done(nb, kd);
    chk("div_negb_lo", 64'(lo), 64'hFFFF_FFFD);
    chk("div_negb_hi", 64'(hi), 64'h1);

    // DIV overflow
    start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(nb, kd);
    chk("div_ovf_lo", 64'(lo), 64'h8000_0000);
    chk("div_ovf_hi", 64'(hi), 64'h0);

    // MULT min x min
    start_op(2'b00, 32'h8000_0000, 32'h8000_0000);
    wait_done(nb, kd);
    chk("mult_min_hi", 64'(hi), 64'h4000_0000);
    chk("mult_min_lo", 64'(lo), 64'h0);

    // DIVU 100 / 0
    start_op(2'b11, 32'd100, 32'd0);
    wait_done(nb, kd);
    chk("divz_busy_cycles", 64'(nb), 64'(EO_LAT));
    chk("divz_lat", 64'(kd), 64'(EO_LAT));
    chk("divz_hi", 64'(hi), 64'd100);
    chk("divz_lo", 64'(lo), 64'hFFFF_FFFF);

    // DIV -100 / 0: raw dividend bits, no sign fix
    start_op(2'b10, 32'hFFFF_FF9C, 32'd0);
    wait_done(nb, kd);
    chk("sdivz_hi", 64'(hi), 64'hFFFF_FF9C);
    chk("sdivz_lo", 64'(lo), 64'hFFFF_FFFF);

    // MULT 0 x 5
    start_op(2'b00, 32'd0, 32'd5);
    wait_done(nb, kd);
    chk("mulz_lat", 64'(kd), 64'(EO_LAT));
    chk("mulz_hi", 64'(hi), 64'h0);
    chk("mulz_lo", 64'(lo), 64'h0);

    // start + MTHI at the same IDLE edge: write lands, then result overwrites
    @(negedge clk);
    op = 2'b01; src_a = 32'd2; src_b = 32'd3; start = 1'b1; hi_we = 1'b1; wdata = 32'h55;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    chk("same_edge_hi", 64'(hi), 64'h55);
    wait_done(nb, kd);
    chk("same_edge_res_hi", 64'(hi), 64'h0);
    chk("same_edge_res_lo", 64'(lo), 64'd6);

    // MTHI 0x1234, then MULT 3x5 with start/hi_we pulsed while busy
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi2_hi", 64'(hi), 64'h1234);
    start_op(2'b00, 32'd3, 32'd5);
    repeat (3) @(negedge clk);
    op = 2'b11; src_a = 32'd9; src_b = 32'd2; start = 1'b1; hi_we = 1'b1; wdata = 32'hAAAA;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    chk("busy_write_dropped", 64'(hi), 64'h1234);
    wait_done(nb, kd);
    chk("busy_mult_hi", 64'(hi), 64'h0);
    chk("busy_mult_lo", 64'(lo), 64'd15);
    @(negedge clk);
    chk("busy_start_ignored", 64'(busy), 64'(0));

    // Reset mid-operation
    start_op(2'b00, 32'd3, 32'd5);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    chk("midrst_hi",   64'(hi),   64'h0);
    chk("midrst_lo",   64'(lo),   64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    npulse = 0;
    for (int k = 0; k < N + 8; k++) begin
      @(negedge clk);
      if (done) npulse++;
    end
    chk("midrst_no_done", 64'(npulse), 64'(0));
    chk("midrst_idle", 64'(busy), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit (MDU) in the EX stage. Executes MULT, MULTU, DIV and DIVU over multiple cycles and holds the HI/LO registers.
- HI/LO feed the writeback-select 2:1 muxes for MFHI/MFLO.
- busy drives the hazard logic, which stalls dependent MFHI/MFLO until done.
- Also accepts MTHI/MTLO writes.

Parameters:
- N, 32, operand width; HI and LO are each N bits.
- CW, 6, iteration counter width; must satisfy 2^CW >= N.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  launch an operation; sampled only in IDLE.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- src_a  in  N  multiplicand / dividend (rs).
- src_b  in  N  multiplier / divisor (rt).
- hi_we  in  1  MTHI write strobe.
- lo_we  in  1  MTLO write strobe.
- wdata  in  N  MTHI/MTLO data.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; HI/LO valid with the new result.
- hi  out  N  HI register (product high half / remainder).
- lo  out  N  LO register (product low half / quotient).

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset: state=IDLE; counter, internal accumulators, busy, done, hi, lo all 0. Applies immediately, mid-operation included; an in-flight result is discarded.
- States: IDLE, CALC, FIX.
- IDLE -> CALC on start=1 at an edge.
  - At that edge, latch op and the operand magnitudes: absolute value for signed ops, raw value for unsigned.
  - Record result signs: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
  - counter <= N-1; busy <= 1.
- CALC: one iteration per cycle, N cycles total.
  - Multiply: shift-add, 2N-bit accumulator.
  - Divide: restoring, one quotient bit per cycle, remainder width N+1.
  - counter decrements each cycle; CALC -> FIX when counter==0.
- FIX: apply two's-complement sign correction.
  - Multiply: correct the 2N-bit product.
  - Divide: correct quotient and remainder separately.
  - FIX -> IDLE at the next edge. At that edge: write hi/lo, done <= 1, busy <= 0.
- Latency: start sampled at edge t gives busy=1 from t until t+N+1, and done=1 for exactly the cycle following edge t+N+1. Total N+2 cycles.
- Single-cycle done: done deasserts at the next edge unconditionally.
- start with busy=1: ignored. No queueing, no error.
- start in the done cycle (state IDLE): accepted. Back-to-back operations are legal.
- Divide by zero (src_b==0): full N cycles, then HI=src_a unchanged (original, unsigned-interpreted bits), LO=all ones. No sign fix.
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0. Falls out naturally from magnitude arithmetic; no special case.
- Division convention: quotient truncates toward zero; remainder sign follows the dividend; remainder 0 is never negated.
- MTHI/MTLO:
  - In IDLE, hi_we/lo_we write wdata at the edge; reads see it the next cycle.
  - While busy=1, writes are dropped.
  - If start and hi_we/lo_we are asserted at the same IDLE edge, the write occurs, then is overwritten by the result at done.
- hi/lo hold their values except on a result write, an accepted MTHI/MTLO, or reset.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined: in IDLE with start=1, if (multiply and either operand==0) or (divide and src_b==0), skip CALC and go straight to FIX.
  - busy=1 for one cycle; done pulses the cycle after edge t+1.
  - Results are identical to the full-length path: multiply gives HI=LO=0; divide-by-zero gives HI=src_a, LO=all ones.
- Undefined: every operation takes N+2 cycles. No zero-detect logic is synthesized.

Test Plan:
- MULT src_a=7, src_b=0xFFFFFFFD (-3) -> done after N+2 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy high exactly N+1 cycles.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Follow with back-to-back DIVU 100/7 started in the done cycle -> LO=14, HI=2.
- DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 100 / 0 -> HI=100, LO=0xFFFFFFFF. Latency N+2 without the macro, 2 with MDU_EARLY_OUT_EN.
- MTHI 0x1234 in IDLE -> hi=0x1234 next cycle. During a busy MULT 3x5, pulse start, hi_we (wdata=0xAAAA) and rst_n:
  - Before reset, start and hi_we are ignored; the MULT result is HI=0, LO=15.
  - A new run with rst_n pulsed low at CALC cycle 5 gives busy=0, done=0, hi=lo=0 immediately, and no done pulse follows.
